unified_mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported, fixed-latency word memory between the core's instruction-fetch port and its load/store data port. It replaces the separate instruction and data memories in a unified-memory build. The datapath stalls its PC and pipeline stage on the ready handshakes. Each transaction moves through a four-state FSM: select, issue, wait out the memory latency, return.

---
 rtl/unified_mem_arbiter_pkg.sv | 18 +
 rtl/unified_mem_arbiter_if.sv | 34 +++
 rtl/unified_mem_arb_pick.sv | 33 +++
 rtl/unified_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam logic [31:0] RST_WORD = 32'h0;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Core-side request/response and memory-side bus of the unified memory arbiter.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 6
);
   logic              if_req;
   logic [31:0]       if_addr;
   logic [31:0]       if_rdata;
   logic              if_ready;
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              arb_busy;

   // master: the arbiter itself; slave: the core ports plus the memory
   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready,
             mem_en, mem_we, mem_addr, mem_wdata, arb_busy
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready,
             mem_en, mem_we, mem_addr, mem_wdata, arb_busy
   );
endinterface

// File: rtl/unified_mem_arb_pick.sv
// Combinational request picker; UNIFIED_MEM_ARB_RR_EN selects round-robin on a tie,
// otherwise the data port always wins a tie.
module unified_mem_arb_pick
   import unified_mem_arbiter_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
   input  owner_e last_grant,
   output logic   grant_valid,
   output owner_e grant_owner
);

   owner_e tie_owner;

`ifdef UNIFIED_MEM_ARB_RR_EN
   assign tie_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign tie_owner = OWN_D;
`endif

   always_comb begin
      grant_valid = if_req | d_req;
      grant_owner = OWN_I;
      if (if_req && d_req) begin
         grant_owner = tie_owner;
      end else if (d_req) begin
         grant_owner = OWN_D;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port word memory between fetch and load/store ports.
// UNIFIED_MEM_ARB_RR_EN enables round-robin tie breaking with a last-grant register.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = 6
) (
   input logic                   clk,
   input logic                   rst,
   unified_mem_arbiter_if.master bus
);
   // state | meaning
   // IDLE  | arbitrate, latch owner/address/we/wdata on any request
   // ISSUE | mem_en for one cycle, load latency counter
   // WAIT  | count down, capture mem_rdata at terminal count
   // DONE  | pulse owner's ready

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         d_rdata_q, d_rdata_d;
   owner_e              last_grant;
   logic                grant_valid;
   owner_e              grant_owner;
   logic                unused_addr_bits;

   // word addressing drops the byte offset and anything above the memory size
   assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                               bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

`ifdef UNIFIED_MEM_ARB_RR_EN
   owner_e last_grant_q, last_grant_d;
   assign last_grant = last_grant_q;
`else
   assign last_grant = OWN_I;
`endif

   unified_mem_arb_pick u_pick (
      .if_req      (bus.if_req),
      .d_req       (bus.d_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
`ifdef UNIFIED_MEM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d = grant_owner;
               state_d = ISSUE;
               if (grant_owner == OWN_D) begin
                  mem_addr_d  = bus.d_addr[ADDR_W+1:2];
                  mem_we_d    = bus.d_we;
                  mem_wdata_d = bus.d_wdata;
               end else begin
                  mem_addr_d  = bus.if_addr[ADDR_W+1:2];
                  mem_we_d    = 1'b0;
                  mem_wdata_d = RST_WORD;
               end
            end
         end
         ISSUE: begin
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = WAIT;
`ifdef UNIFIED_MEM_ARB_RR_EN
            last_grant_d = owner_q;
`endif
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               if (owner_q == OWN_I) begin
                  if_rdata_d = bus.mem_rdata;
               end else if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end
         end
         DONE: begin
            state_d     = IDLE;
            mem_addr_d  = '0;
            mem_we_d    = 1'b0;
            mem_wdata_d = RST_WORD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= RST_WORD;
         if_rdata_q  <= RST_WORD;
         d_rdata_q   <= RST_WORD;
`ifdef UNIFIED_MEM_ARB_RR_EN
         last_grant_q <= OWN_I;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
`ifdef UNIFIED_MEM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign bus.mem_en    = (state_q == ISSUE);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_ready  = (state_q == DONE) && (owner_q == OWN_I);
   assign bus.d_ready   = (state_q == DONE) && (owner_q == OWN_D);
   assign bus.arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with MEM_LAT=2 and a 2-cycle memory model.
module tb_unified_mem_arbiter;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   unified_mem_arbiter_if #(.ADDR_W(6)) bus ();

   unified_mem_arbiter #(.MEM_LAT(2), .ADDR_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous memory: read data valid two cycles after the mem_en cycle
   logic [31:0] mem_model [64];
   logic        v1, v2;
   logic [5:0]  a1, a2;

   always @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         mem_model[4]  <= 32'h00500093;
         mem_model[5]  <= 32'h00A00113;
         mem_model[10] <= 32'h12345678;
         mem_model[11] <= 32'hCAFEF00D;
      end else begin
         v1 <= bus.mem_en && !bus.mem_we;
         a1 <= bus.mem_addr;
         v2 <= v1;
         a2 <= a1;
         if (bus.mem_en && bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   assign bus.mem_rdata = v2 ? mem_model[a2] : 32'hBAD0BAD0;

   logic [4:0] exp_ctl, got_ctl;
   logic [5:0] exp_addr;

   task automatic test_reset();
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         got_ctl = {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.arb_busy};
         n_tests++;
         if (got_ctl !== 5'b0 || bus.mem_addr !== 6'd0 || bus.mem_wdata !== 32'h0 ||
             bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset c=%0d ctl=%b addr=%0d wdata=%h if_rdata=%h d_rdata=%h, want all 0",
                     c, got_ctl, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
         end
         @(posedge clk); #1;
         rst = 1'b0;
      end
   endtask

   task automatic test_tie();
      bus.if_req = 1'b1; bus.if_addr = 32'h14;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h28;
`ifdef UNIFIED_MEM_ARB_RR_EN
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         exp_ctl = {(c == 1 || c == 6 || c == 11 || c == 16), 1'b0,
                    (c == 9 || c == 19), (c == 4 || c == 14), (c % 5 != 0)};
         exp_addr = (c % 5 == 0) ? 6'd0 : (((c / 5) % 2 == 0) ? 6'd10 : 6'd5);
         got_ctl = {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.arb_busy};
         n_tests++;
         if (got_ctl !== exp_ctl || bus.mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL rr_tie c=%0d ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     c, got_ctl, bus.mem_addr, exp_ctl, exp_addr);
         end
         if (c == 4 || c == 9) begin
            n_tests++;
            if (bus.d_rdata !== 32'h12345678 || (c == 9 && bus.if_rdata !== 32'h00A00113)) begin
               n_fail++;
               $display("FAIL rr_tie_data c=%0d d_rdata=%h if_rdata=%h, want 12345678 / 00a00113",
                        c, bus.d_rdata, bus.if_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 19) begin bus.if_req = 1'b0; bus.d_req = 1'b0; end
      end
`else
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         exp_ctl = {(c == 1 || c == 6), 1'b0, (c == 9), (c == 4), (c % 5 != 0)};
         exp_addr = (c % 5 == 0) ? 6'd0 : ((c < 5) ? 6'd10 : 6'd5);
         got_ctl = {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.arb_busy};
         n_tests++;
         if (got_ctl !== exp_ctl || bus.mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL fixed_tie c=%0d ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     c, got_ctl, bus.mem_addr, exp_ctl, exp_addr);
         end
         if (c == 4 || c == 9) begin
            n_tests++;
            if (bus.d_rdata !== 32'h12345678 || (c == 9 && bus.if_rdata !== 32'h00A00113)) begin
               n_fail++;
               $display("FAIL fixed_tie_data c=%0d d_rdata=%h if_rdata=%h, want 12345678 / 00a00113",
                        c, bus.d_rdata, bus.if_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 4) bus.d_req = 1'b0;
         if (c == 9) bus.if_req = 1'b0;
      end
`endif
   endtask

   task automatic test_fetch();
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         exp_ctl = {(c == 1), 1'b0, (c == 4), 1'b0, (c >= 1 && c <= 4)};
         exp_addr = (c >= 1 && c <= 4) ? 6'd4 : 6'd0;
         got_ctl = {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.arb_busy};
         n_tests++;
         if (got_ctl !== exp_ctl || bus.mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL fetch c=%0d ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     c, got_ctl, bus.mem_addr, exp_ctl, exp_addr);
         end
         if (c == 4) begin
            n_tests++;
            if (bus.if_rdata !== 32'h00500093) begin
               n_fail++;
               $display("FAIL fetch_rdata got=%h want=00500093", bus.if_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 4) bus.if_req = 1'b0;
      end
   endtask

   task automatic test_load_addr_bits();
      // byte offset 3 and a high address bit must both be ignored: word 11
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000_002F;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         exp_ctl = {(c == 1), 1'b0, 1'b0, (c == 4), (c >= 1 && c <= 4)};
         exp_addr = (c >= 1 && c <= 4) ? 6'd11 : 6'd0;
         got_ctl = {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.arb_busy};
         n_tests++;
         if (got_ctl !== exp_ctl || bus.mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL load c=%0d ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     c, got_ctl, bus.mem_addr, exp_ctl, exp_addr);
         end
         if (c == 4) begin
            n_tests++;
            if (bus.d_rdata !== 32'hCAFEF00D) begin
               n_fail++;
               $display("FAIL load_rdata got=%h want=cafef00d", bus.d_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 4) bus.d_req = 1'b0;
      end
   endtask

   task automatic test_store();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h24; bus.d_wdata = 32'hDEADBEEF;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         exp_ctl = {(c == 1), (c >= 1 && c <= 4), 1'b0, (c == 4), (c >= 1 && c <= 4)};
         exp_addr = (c >= 1 && c <= 4) ? 6'd9 : 6'd0;
         got_ctl = {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.arb_busy};
         n_tests++;
         if (got_ctl !== exp_ctl || bus.mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL store c=%0d ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     c, got_ctl, bus.mem_addr, exp_ctl, exp_addr);
         end
         n_tests++;
         if (bus.mem_wdata !== ((c >= 1 && c <= 4) ? 32'hDEADBEEF : 32'h0) ||
             bus.d_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL store_data c=%0d wdata=%h d_rdata=%h, want wdata=%h d_rdata=cafef00d",
                     c, bus.mem_wdata, bus.d_rdata,
                     (c >= 1 && c <= 4) ? 32'hDEADBEEF : 32'h0);
         end
         @(posedge clk); #1;
         if (c == 4) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
      end
      n_tests++;
      if (mem_model[9] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL store_mem got=%h want=deadbeef", mem_model[9]);
      end
   endtask

   task automatic test_reset_mid();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h28;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         exp_ctl = {(c == 1 || c == 5), 1'b0, (c == 8), 1'b0,
                    ((c >= 1 && c <= 2) || (c >= 5 && c <= 8))};
         exp_addr = (c >= 1 && c <= 2) ? 6'd10 : ((c >= 5 && c <= 8) ? 6'd4 : 6'd0);
         got_ctl = {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.arb_busy};
         n_tests++;
         if (got_ctl !== exp_ctl || bus.mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL reset_mid c=%0d ctl=%b addr=%0d, want ctl=%b addr=%0d",
                     c, got_ctl, bus.mem_addr, exp_ctl, exp_addr);
         end
         if (c == 3) begin
            n_tests++;
            if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0 || bus.mem_wdata !== 32'h0) begin
               n_fail++;
               $display("FAIL reset_mid_regs if_rdata=%h d_rdata=%h wdata=%h, want 0",
                        bus.if_rdata, bus.d_rdata, bus.mem_wdata);
            end
         end
         if (c == 8) begin
            n_tests++;
            if (bus.if_rdata !== 32'h00500093) begin
               n_fail++;
               $display("FAIL reset_mid_fetch got=%h want=00500093", bus.if_rdata);
            end
         end
         @(posedge clk); #1;
         if (c == 1) rst = 1'b1;
         if (c == 2) begin rst = 1'b0; bus.d_req = 1'b0; end
         if (c == 3) begin bus.if_req = 1'b1; bus.if_addr = 32'h10; end
         if (c == 8) bus.if_req = 1'b0;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_tie();
      test_fetch();
      test_load_addr_bits();
      test_store();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
